// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Round-robin write arbiter for two producers sharing a small bank of
// enable-D flip-flop registers. At most one write is granted per cycle; the
// winner sees a one-cycle ack, and the registered one-hot enable and data
// bus drive the bank one edge later. The bank itself lives inside this
// module, so this block is the only source of its enables.
//
// Ports:
//   clk                 single clock, rising-edge
//   reset_n             asynchronous active-low reset
//   req0/addr0/wdata0   write request, target register and data, requester 0
//   req1/addr1/wdata1   write request, target register and data, requester 1
//   ack0/ack1           one-cycle grant pulse to the winning requester
//   en                  registered one-hot bank enable (all zero when idle)
//   d                   registered bank write data (holds when idle)
//   last_grant          requester that most recently won (0 or 1)
//   raddr               read address
//   rdata               combinational read of bank[raddr], 0 if out of range
// ---------------------------------------------------------------------------
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [NREG-1:0]  en,
  output logic [WIDTH-1:0] d,
  output logic             last_grant,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             elig0;
  logic             elig1;
  logic [NREG-1:0]  dec0;
  logic [NREG-1:0]  dec1;
  logic [WIDTH-1:0] bank [NREG];

  // The acks are decoded straight from the registered state, so they carry
  // no combinational path from the request inputs.
  assign ack0 = (state == G0);
  assign ack1 = (state == G1);

  // A requester still seeing its own ack is holding req only until it
  // samples that ack, so it must not be granted again on this edge.
  assign elig0 = req0 & ~ack0;
  assign elig1 = req1 & ~ack1;

  // Address decode per requester. Addresses at or above NREG match no bit,
  // which yields an all-zero enable: the write is acked but lands nowhere.
  always_comb begin
    dec0 = '0;
    dec1 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr0 == AW'(i)) dec0[i] = 1'b1;
      if (addr1 == AW'(i)) dec1[i] = 1'b1;
    end
  end

  // Round-robin choice: on contention the requester that did not win last
  // time gets the grant.
  always_comb begin
    state_next = IDLE;
    if (elig0 && elig1) begin
      state_next = last_grant ? G0 : G1;
    end else if (elig0) begin
      state_next = G0;
    end else if (elig1) begin
      state_next = G1;
    end
  end

  // Enable and data are loaded on the same edge that enters a grant state,
  // so they line up with the ack cycle. In idle the enable drops but the
  // data bus keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      en         <= '0;
      d          <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      case (state_next)
        G0: begin
          en         <= dec0;
          d          <= wdata0;
          last_grant <= 1'b0;
        end
        G1: begin
          en         <= dec1;
          d          <= wdata1;
          last_grant <= 1'b1;
        end
        default: begin
          en <= '0;
        end
      endcase
    end
  end

  // The bank: each register is an enable-D flop fed by the shared data bus.
  // A reset that arrives during a grant clears en/d and the bank together,
  // so the pending write never lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (en[i]) bank[i] <= d;
      end
    end
  end

  // Read port; out-of-range read addresses match nothing and return zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (raddr == AW'(i)) rdata = bank[i];
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Scoreboard bench for reg_bank_arbiter. Stimulus pushes the expected grant
// (which ack, enable, data, last_grant) into a queue before driving the
// requests; a monitor per instance pops and compares at every falling edge
// where the DUT shows an ack. Instance A uses the default 4-register bank,
// instance B a 3-register bank so that address 3 is out of range.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  logic       req0, req1, ack0, ack1, last_grant;
  logic [1:0] addr0, addr1, raddr;
  logic [7:0] wdata0, wdata1, d, rdata;
  logic [3:0] en;

  logic       b_req0, b_req1, b_ack0, b_ack1, b_last_grant;
  logic [1:0] b_addr0, b_addr1, b_raddr;
  logic [7:0] b_wdata0, b_wdata1, b_d, b_rdata;
  logic [2:0] b_en;

  typedef struct packed {
    logic       ack0;
    logic       ack1;
    logic [3:0] en;
    logic [7:0] d;
    logic       lg;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  reg_bank_arbiter #(.WIDTH(8), .NREG(4), .AW(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .en(en), .d(d), .last_grant(last_grant),
    .raddr(raddr), .rdata(rdata)
  );

  reg_bank_arbiter #(.WIDTH(8), .NREG(3), .AW(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(b_req0), .addr0(b_addr0), .wdata0(b_wdata0),
    .req1(b_req1), .addr1(b_addr1), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .en(b_en), .d(b_d), .last_grant(b_last_grant),
    .raddr(b_raddr), .rdata(b_rdata)
  );

  always #10 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for instance A: every ack cycle must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (ack0 || ack1)) begin
      if (q_a.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL a_unexpected_ack: got ack0=%0b ack1=%0b, expected no ack", ack0, ack1);
      end else begin
        e = q_a.pop_front();
        check_output("a_ack0", 32'(ack0), 32'(e.ack0));
        check_output("a_ack1", 32'(ack1), 32'(e.ack1));
        check_output("a_en", 32'(en), 32'(e.en));
        check_output("a_d", 32'(d), 32'(e.d));
        check_output("a_last_grant", 32'(last_grant), 32'(e.lg));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (b_ack0 || b_ack1)) begin
      if (q_b.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL b_unexpected_ack: got ack0=%0b ack1=%0b, expected no ack", b_ack0, b_ack1);
      end else begin
        e = q_b.pop_front();
        check_output("b_ack0", 32'(b_ack0), 32'(e.ack0));
        check_output("b_ack1", 32'(b_ack1), 32'(e.ack1));
        check_output("b_en", 32'({1'b0, b_en}), 32'(e.en));
        check_output("b_d", 32'(b_d), 32'(e.d));
        check_output("b_last_grant", 32'(b_last_grant), 32'(e.lg));
      end
    end
  end

  function automatic exp_t mk(input logic a0, input logic a1, input logic [3:0] e,
                              input logic [7:0] v, input logic lg);
    exp_t r;
    r.ack0 = a0;
    r.ack1 = a1;
    r.en   = e;
    r.d    = v;
    r.lg   = lg;
    return r;
  endfunction

  // Requester tasks: present a transaction, hold it until the ack is seen
  // (bounded), then drop the request. Called on a falling edge.
  task automatic drive_a0(input logic [1:0] a, input logic [7:0] v);
    logic seen = 1'b0;
    req0 = 1'b1; addr0 = a; wdata0 = v;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack0) seen = 1'b1;
    end
    check_output("a_ack0_seen", 32'(seen), 32'd1);
    req0 = 1'b0;
  endtask

  task automatic drive_a1(input logic [1:0] a, input logic [7:0] v);
    logic seen = 1'b0;
    req1 = 1'b1; addr1 = a; wdata1 = v;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack1) seen = 1'b1;
    end
    check_output("a_ack1_seen", 32'(seen), 32'd1);
    req1 = 1'b0;
  endtask

  task automatic drive_b0(input logic [1:0] a, input logic [7:0] v);
    logic seen = 1'b0;
    b_req0 = 1'b1; b_addr0 = a; b_wdata0 = v;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (b_ack0) seen = 1'b1;
    end
    check_output("b_ack0_seen", 32'(seen), 32'd1);
    b_req0 = 1'b0;
  endtask

  task automatic read_a(input logic [1:0] r, input logic [7:0] exp);
    raddr = r;
    #1;
    check_output($sformatf("a_rdata[%0d]", r), 32'(rdata), 32'(exp));
  endtask

  task automatic read_b(input logic [1:0] r, input logic [7:0] exp);
    b_raddr = r;
    #1;
    check_output($sformatf("b_rdata[%0d]", r), 32'(b_rdata), 32'(exp));
  endtask

  // Short reset pulse placed well away from the rising edge.
  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_stimulus();
    // Reset state and single write
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_ack0", 32'(ack0), 32'd0);
    check_output("rst_ack1", 32'(ack1), 32'd0);
    check_output("rst_en", 32'(en), 32'd0);
    check_output("rst_d", 32'(d), 32'd0);
    check_output("rst_last_grant", 32'(last_grant), 32'd1);
    for (int i = 0; i < 4; i++) read_a(2'(i), 8'h00);
    @(negedge clk);
    q_a.push_back(mk(1'b1, 1'b0, 4'b0100, 8'hA5, 1'b0));
    drive_a0(2'd2, 8'hA5);
    @(negedge clk);
    check_output("a_ack0_one_cycle", 32'(ack0), 32'd0);
    read_a(2'd2, 8'hA5);
    read_a(2'd0, 8'h00);
    read_a(2'd1, 8'h00);
    read_a(2'd3, 8'h00);

    // Contention straight out of reset: requester 0 first
    reset_pulse();
    q_a.push_back(mk(1'b1, 1'b0, 4'b0001, 8'h11, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b0010, 8'h22, 1'b1));
    fork
      drive_a0(2'd0, 8'h11);
      drive_a1(2'd1, 8'h22);
    join
    @(negedge clk);
    read_a(2'd0, 8'h11);
    read_a(2'd1, 8'h22);
    check_output("contention_last_grant", 32'(last_grant), 32'd1);

    // Continuous contention: grants must alternate 0,1,0,1,...
    q_a.push_back(mk(1'b1, 1'b0, 4'b0001, 8'hA0, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b0010, 8'hB0, 1'b1));
    q_a.push_back(mk(1'b1, 1'b0, 4'b0100, 8'hA1, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b1000, 8'hB1, 1'b1));
    q_a.push_back(mk(1'b1, 1'b0, 4'b0001, 8'hA2, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b0010, 8'hB2, 1'b1));
    q_a.push_back(mk(1'b1, 1'b0, 4'b0100, 8'hA3, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b1000, 8'hB3, 1'b1));
    fork
      begin
        drive_a0(2'd0, 8'hA0);
        drive_a0(2'd2, 8'hA1);
        drive_a0(2'd0, 8'hA2);
        drive_a0(2'd2, 8'hA3);
      end
      begin
        drive_a1(2'd1, 8'hB0);
        drive_a1(2'd3, 8'hB1);
        drive_a1(2'd1, 8'hB2);
        drive_a1(2'd3, 8'hB3);
      end
    join
    @(negedge clk);
    read_a(2'd0, 8'hA2);
    read_a(2'd1, 8'hB2);
    read_a(2'd2, 8'hA3);
    read_a(2'd3, 8'hB3);

    // Same-address collision: last winner was 1, so 0 goes first, 1 second
    q_a.push_back(mk(1'b1, 1'b0, 4'b1000, 8'h0F, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b1000, 8'hF0, 1'b1));
    fork
      drive_a0(2'd3, 8'h0F);
      drive_a1(2'd3, 8'hF0);
    join
    @(negedge clk);
    read_a(2'd3, 8'hF0);

    // Reset in the middle of a G1 cycle discards the pending write
    q_a.push_back(mk(1'b0, 1'b1, 4'b0100, 8'h5A, 1'b1));
    drive_a1(2'd2, 8'h5A);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("midrst_ack1", 32'(ack1), 32'd0);
    check_output("midrst_en", 32'(en), 32'd0);
    check_output("midrst_d", 32'(d), 32'd0);
    check_output("midrst_last_grant", 32'(last_grant), 32'd1);
    for (int i = 0; i < 4; i++) read_a(2'(i), 8'h00);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    read_a(2'd2, 8'h00);
    q_a.push_back(mk(1'b1, 1'b0, 4'b0010, 8'h66, 1'b0));
    q_a.push_back(mk(1'b0, 1'b1, 4'b0100, 8'h99, 1'b1));
    fork
      drive_a0(2'd1, 8'h66);
      drive_a1(2'd2, 8'h99);
    join
    @(negedge clk);
    read_a(2'd0, 8'h00);
    read_a(2'd1, 8'h66);
    read_a(2'd2, 8'h99);
    read_a(2'd3, 8'h00);

    // Out-of-range write on the 3-register instance
    q_b.push_back(mk(1'b1, 1'b0, 4'b0010, 8'h77, 1'b0));
    drive_b0(2'd1, 8'h77);
    q_b.push_back(mk(1'b1, 1'b0, 4'b0000, 8'hFF, 1'b0));
    drive_b0(2'd3, 8'hFF);
    @(negedge clk);
    read_b(2'd0, 8'h00);
    read_b(2'd1, 8'h77);
    read_b(2'd2, 8'h00);
    read_b(2'd3, 8'h00);
  endtask

  initial begin
    req0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0;
    raddr = '0;
    b_req0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 1'b0; b_addr1 = '0; b_wdata1 = '0;
    b_raddr = '0;
    apply_stimulus();
    @(negedge clk);
    check_output("a_queue_drained", 32'(q_a.size()), 32'd0);
    check_output("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
